// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// counter-width helper and the legal operand-width range.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bits needed to count 0..w-1; never less than one bit.
  function automatic int CNT_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder; the only arithmetic element of the
// serial adder.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures A, B and Cin, then pushes them LSB-first
// through one full-adder cell, one bit per clock, building the sum in a
// shift register. The optional signed-overflow output is enabled by
// defining SIGNED_OVF_EN.
//
// Handshake: start is sampled only while idle (busy=0); an accepted start
// captures A/B/Cin on that edge. busy is high while shifting and during the
// result cycle, and any start seen then is dropped, never queued. done is a
// single-cycle pulse marking Sum/Cout (and Ovf) valid; they then hold until
// the next done. A start held high simply re-triggers on the first idle edge.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [1:0]       dbg_state
`ifdef SIGNED_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CNT_WIDTH = CNT_W(WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIDTH - 1);

  // Reject widths outside the supported range at elaboration.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_e               state;
  logic [WIDTH-1:0]     a_sr;
  logic [WIDTH-1:0]     b_sr;
  logic [WIDTH-1:0]     s_sr;
  logic                 carry;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cell_s;
  logic                 cell_cout;
`ifdef SIGNED_OVF_EN
  logic                 ovf_q;
`endif

  // The single full-adder cell sees the current LSBs and the running carry.
  fa_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign dbg_state = state;

  // Controller FSM with the shift registers, carry, counter and output regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= {cell_s, s_sr[WIDTH-1:1]};
          carry <= cell_cout;
          if (cnt == CNT_LAST) begin
            // MSB is being added: carry is the carry into it.
            cnt   <= '0;
            state <= ST_DONE;
`ifdef SIGNED_OVF_EN
            ovf_q <= carry ^ cell_cout;
`endif
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          Sum   <= s_sr;
          Cout  <= carry;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef SIGNED_OVF_EN
          Ovf   <= ovf_q;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results
// come from an A+B+Cin model pushed to a queue at start time and popped
// when done pulses. Define SIGNED_OVF_EN to also check Ovf.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic [1:0]       dbg_state;
`ifdef SIGNED_OVF_EN
  logic             Ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  // {ovf, cout, sum}
  logic [WIDTH+1:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .busy      (busy),
    .done      (done),
    .Sum       (Sum),
    .Cout      (Cout),
    .dbg_state (dbg_state)
`ifdef SIGNED_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  // ---------------- clock / reset / monitors ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH:0] t;
    logic ovf;
    t = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return {ovf, t};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge while idle; returns at the negedge after acceptance.
  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input bit push);
    A = a;
    B = b;
    Cin = cin;
    start = 1'b1;
    if (push) exp_q.push_back(model(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; n = negedges waited, nb = busy samples seen.
  task automatic wait_done(output int n, output int nb, output bit ok);
    n = 0;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, Cout, Sum, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h state=%0d, required all 0",
               busy, done, Cout, Sum, dbg_state);
    end
`ifdef SIGNED_OVF_EN
    checks++;
    if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", Ovf); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b state=%0d required 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_zero();
    int n, nb;
    bit ok;
    logic [WIDTH+1:0] e;
    drive_start(8'h00, 8'h00, 1'b0, 1'b1);
    wait_done(n, nb, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_timeout: no done within bound");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (n !== 9) begin errors++; $display("FAIL zero_latency: got %0d required 9", n); end
      checks++;
      if (nb !== 9) begin errors++; $display("FAIL zero_busy_cycles: got %0d required 9", nb); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done: got %b required 0", busy); end
      checks++;
      if ({Cout, Sum} !== e[WIDTH:0]) begin
        errors++;
        $display("FAIL zero_result: got %b_%h required %b_%h", Cout, Sum, e[WIDTH], e[WIDTH-1:0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b required 0", done); end
    end
  endtask

  task automatic test_add(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin);
    int n, nb;
    bit ok;
    logic [WIDTH+1:0] e;
    drive_start(a, b, cin, 1'b1);
    wait_done(n, nb, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: no done within bound", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({Cout, Sum} !== e[WIDTH:0]) begin
        errors++;
        $display("FAIL %s_result: got %b_%h required %b_%h", name, Cout, Sum, e[WIDTH], e[WIDTH-1:0]);
      end
`ifdef SIGNED_OVF_EN
      checks++;
      if (Ovf !== e[WIDTH+1]) begin
        errors++;
        $display("FAIL %s_ovf: got %b required %b", name, Ovf, e[WIDTH+1]);
      end
`endif
      // Result must hold after the pulse.
      repeat (3) @(negedge clk);
      checks++;
      if ({Cout, Sum} !== e[WIDTH:0]) begin
        errors++;
        $display("FAIL %s_hold: got %b_%h required %b_%h", name, Cout, Sum, e[WIDTH], e[WIDTH-1:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    logic [WIDTH+1:0] e;
    d0 = done_cnt;
    drive_start(8'hA5, 8'h5A, 1'b1, 1'b1);
    // Mid-operation start with new operands.
    repeat (3) @(negedge clk);
    A = 8'hFF;
    B = 8'hFF;
    Cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Start during the result cycle.
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done_timing: done=%b required 1 at cycle 9", done);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({Cout, Sum} !== e[WIDTH:0]) begin
        errors++;
        $display("FAIL ignore_result: got %b_%h required %b_%h", Cout, Sum, e[WIDTH], e[WIDTH-1:0]);
      end
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_single_done: dones=%0d busy=%b required 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    drive_start(8'h3C, 8'h0F, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Cout, Sum, dbg_state} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b cout=%b sum=%h state=%0d, required all 0",
               busy, done, Cout, Sum, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d busy=%b required 0/0", done_cnt - d0, busy);
    end
    test_add("after_abort", 8'h3C, 8'h0F, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, nb, last;
    bit ok;
    logic [WIDTH+1:0] e;
    logic [WIDTH-1:0] a, b;
    logic c;
    a = 8'hFF;
    b = 8'hFF;
    c = 1'b1;
    A = a;
    B = b;
    Cin = c;
    start = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge clk);
    @(negedge clk);
    last = 0;
    for (int i = 0; i < 40; i++) begin
      wait_done(n, nb, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_timeout: op %0d no done within bound", i);
        break;
      end
      if (i > 0) begin
        checks++;
        if (cyc - last !== 10) begin
          errors++;
          $display("FAIL b2b_period: op %0d got %0d cycles required 10", i, cyc - last);
        end
      end
      last = cyc;
      e = exp_q.pop_front();
      checks++;
      if ({Cout, Sum} !== e[WIDTH:0]) begin
        errors++;
        $display("FAIL b2b_result: op %0d got %b_%h required %b_%h", i, Cout, Sum, e[WIDTH], e[WIDTH-1:0]);
      end
`ifdef SIGNED_OVF_EN
      checks++;
      if (Ovf !== e[WIDTH+1]) begin
        errors++;
        $display("FAIL b2b_ovf: op %0d got %b required %b", i, Ovf, e[WIDTH+1]);
      end
`endif
      if (i < 39) begin
        a = WIDTH'($urandom_range(255, 0));
        b = WIDTH'($urandom_range(255, 0));
        c = 1'($urandom_range(1, 0));
        A = a;
        B = b;
        Cin = c;
        exp_q.push_back(model(a, b, c));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: queue=%0d busy=%b required 0/0", exp_q.size(), busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero();
    test_add("ff_plus_01", 8'hFF, 8'h01, 1'b0);
    test_add("7f_plus_01", 8'h7F, 8'h01, 1'b0);
    test_ignore_start();
    test_add("80_plus_80", 8'h80, 8'h80, 1'b0);
    test_add("7f_plus_00_c", 8'h7F, 8'h00, 1'b1);
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
